// File: rtl/fetch_pkg.sv
// Shared types and default widths for the fetch sequencer and its helpers.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        ERR  = 2'd3
    } state_t;

    localparam int W_DEF  = 16;
    localparam int AW_DEF = 8;
    localparam int TO_DEF = 15;

endpackage

// File: rtl/pc_cnt.sv
// Program counter register: synchronous reset, clock enable, parallel load
// (jump) with priority over increment, and modulo-2^AW wrap on increment.
module pc_cnt #(
    parameter int AW = 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          en_i,
    input  logic          ld_i,
    input  logic [AW-1:0] ld_val_i,
    input  logic          inc_i,
    output logic [AW-1:0] q_o
);

    logic [AW-1:0] pc_q;
    logic [AW-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (ld_i) begin
            pc_d = ld_val_i;
        end else if (inc_i) begin
            pc_d = pc_q + AW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q <= '0;
        end else if (en_i) begin
            pc_q <= pc_d;
        end
    end

    assign q_o = pc_q;

endmodule

// File: rtl/fetch_seq.sv
// Fetch sequencer: issues single-beat reads at the PC, forwards the response
// word with a one-cycle load strobe, and handles jumps, halt and timeout.
module fetch_seq
    import fetch_pkg::*;
#(
    parameter int W  = W_DEF,
    parameter int AW = AW_DEF,
    parameter int TO = TO_DEF
) (
    input  logic          clk50m,
    input  logic          rst,
    input  logic          en,
    input  logic          start,
    input  logic          halt,
    input  logic          jmp,
    input  logic [AW-1:0] jmp_addr,
    input  logic          clr_err,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rd,
    input  logic [W-1:0]  mem_rdata,
    input  logic          mem_valid,
    output logic [W-1:0]  d,
    output logic          load,
    output logic [AW-1:0] pc,
    output logic          busy,
    output logic          err
);

    state_t        state_q;
    logic [7:0]    cnt_q;
    logic [AW-1:0] mem_addr_q;
    logic          mem_rd_q;
    logic [W-1:0]  d_q;
    logic          load_q;
    logic          busy_q;
    logic          err_q;
    logic          jmp_pend_q;
    logic [AW-1:0] jmp_addr_pend_q;
    logic          halt_pend_q;

    logic          accept;
    logic          pc_ld;
    logic          pc_inc;
    logic [AW-1:0] pc_ld_val;
    logic [AW-1:0] next_pc;

    assign accept    = (state_q == WAIT) && mem_valid;
    assign pc_ld     = ((state_q == IDLE) && jmp) || (accept && jmp_pend_q);
    assign pc_ld_val = (state_q == IDLE) ? jmp_addr : jmp_addr_pend_q;
    assign pc_inc    = accept && !jmp_pend_q;
    assign next_pc   = jmp_pend_q ? jmp_addr_pend_q : pc + AW'(1);

    pc_cnt #(.AW(AW)) u_pc (
        .clk_i    (clk50m),
        .rst_i    (rst),
        .en_i     (en),
        .ld_i     (pc_ld),
        .ld_val_i (pc_ld_val),
        .inc_i    (pc_inc),
        .q_o      (pc)
    );

    always_ff @(posedge clk50m) begin
        if (rst) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            mem_addr_q      <= '0;
            mem_rd_q        <= 1'b0;
            d_q             <= '0;
            load_q          <= 1'b0;
            busy_q          <= 1'b0;
            err_q           <= 1'b0;
            jmp_pend_q      <= 1'b0;
            jmp_addr_pend_q <= '0;
            halt_pend_q     <= 1'b0;
        end else if (!en) begin
            load_q <= 1'b0;
        end else begin
            load_q   <= 1'b0;
            mem_rd_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start && !jmp) begin
                        mem_addr_q <= pc;
                        mem_rd_q   <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= REQ;
                    end
                end
                REQ: begin
                    cnt_q   <= '0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (mem_valid) begin
                        d_q        <= mem_rdata;
                        load_q     <= 1'b1;
                        jmp_pend_q <= 1'b0;
                        if (halt_pend_q || halt) begin
                            halt_pend_q <= 1'b0;
                            busy_q      <= 1'b0;
                            state_q     <= IDLE;
                        end else begin
                            mem_addr_q <= next_pc;
                            mem_rd_q   <= 1'b1;
                            state_q    <= REQ;
                        end
                    end else if (cnt_q == 8'(TO - 1)) begin
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ERR;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                ERR: begin
                    if (clr_err) begin
                        err_q   <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
            // A jump arriving with the response is kept for the following update.
            if ((state_q == REQ || state_q == WAIT) && jmp) begin
                jmp_pend_q      <= 1'b1;
                jmp_addr_pend_q <= jmp_addr;
            end
            if ((state_q == REQ || (state_q == WAIT && !mem_valid)) && halt) begin
                halt_pend_q <= 1'b1;
            end
        end
    end

    assign mem_addr = mem_addr_q;
    assign mem_rd   = mem_rd_q;
    assign d        = d_q;
    assign load     = load_q;
    assign busy     = busy_q;
    assign err      = err_q;

endmodule

// File: tb/tb_fetch_seq.sv
// Directed bench for fetch_seq: reset, fetch latency, wrap, jump+halt,
// timeout/retry, enable stall and mid-transaction reset.
module tb_fetch_seq;

    logic        clk50m;
    logic        rst;
    logic        en;
    logic        start;
    logic        halt;
    logic        jmp;
    logic [7:0]  jmp_addr;
    logic        clr_err;
    logic [7:0]  mem_addr;
    logic        mem_rd;
    logic [15:0] mem_rdata;
    logic        mem_valid;
    logic [15:0] d;
    logic        load;
    logic [7:0]  pc;
    logic        busy;
    logic        err;

    int errors = 0;
    int checks = 0;

    fetch_seq #(.W(16), .AW(8), .TO(15)) dut (
        .clk50m    (clk50m),
        .rst       (rst),
        .en        (en),
        .start     (start),
        .halt      (halt),
        .jmp       (jmp),
        .jmp_addr  (jmp_addr),
        .clr_err   (clr_err),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_rdata (mem_rdata),
        .mem_valid (mem_valid),
        .d         (d),
        .load      (load),
        .pc        (pc),
        .busy      (busy),
        .err       (err)
    );

    initial clk50m = 1'b0;
    always #10 clk50m = ~clk50m;

    task automatic tick();
        @(posedge clk50m);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; start = 1'b0; halt = 1'b0; jmp = 1'b0;
        jmp_addr = 8'h00; clr_err = 1'b0; mem_rdata = 16'h0000; mem_valid = 1'b0;
        tick(); tick();
        rst = 1'b0;
        checks++; if (pc !== 8'h00)     begin errors++; $display("FAIL reset_pc got=%h exp=00", pc); end
        checks++; if (mem_addr !== 8'h00) begin errors++; $display("FAIL reset_mem_addr got=%h exp=00", mem_addr); end
        checks++; if ({mem_rd, load, busy, err} !== 4'b0000) begin errors++; $display("FAIL reset_flags got=%b exp=0000", {mem_rd, load, busy, err}); end
        checks++; if (d !== 16'h0000)   begin errors++; $display("FAIL reset_d got=%h exp=0000", d); end
        $display("reset: pc=%h mem_addr=%h d=%h", pc, mem_addr, d);
    endtask

    task automatic test_basic_fetch();
        start = 1'b1; tick(); start = 1'b0;
        checks++; if (mem_rd !== 1'b1 || mem_addr !== 8'h00 || busy !== 1'b1) begin errors++; $display("FAIL basic_req got rd=%b addr=%h busy=%b exp rd=1 addr=00 busy=1", mem_rd, mem_addr, busy); end
        tick();
        checks++; if (mem_rd !== 1'b0) begin errors++; $display("FAIL basic_rd_pulse got=%b exp=0", mem_rd); end
        mem_valid = 1'b1; mem_rdata = 16'hA5A5; tick(); mem_valid = 1'b0;
        checks++; if (load !== 1'b1 || d !== 16'hA5A5 || pc !== 8'h01) begin errors++; $display("FAIL basic_load got load=%b d=%h pc=%h exp 1 A5A5 01", load, d, pc); end
        checks++; if (mem_rd !== 1'b1 || mem_addr !== 8'h01) begin errors++; $display("FAIL basic_b2b got rd=%b addr=%h exp 1 01", mem_rd, mem_addr); end
        halt = 1'b1; tick(); halt = 1'b0;
        checks++; if (load !== 1'b0) begin errors++; $display("FAIL basic_load_pulse got=%b exp=0", load); end
        mem_valid = 1'b1; mem_rdata = 16'h0001; tick(); mem_valid = 1'b0;
        checks++; if (load !== 1'b1 || busy !== 1'b0 || pc !== 8'h02) begin errors++; $display("FAIL basic_halt got load=%b busy=%b pc=%h exp 1 0 02", load, busy, pc); end
        tick();
        checks++; if (mem_rd !== 1'b0 || load !== 1'b0) begin errors++; $display("FAIL basic_idle got rd=%b load=%b exp 0 0", mem_rd, load); end
        $display("basic fetch: d=%h pc=%h", d, pc);
    endtask

    task automatic test_wrap();
        jmp = 1'b1; jmp_addr = 8'hFF; start = 1'b1; tick(); jmp = 1'b0;
        checks++; if (pc !== 8'hFF || mem_rd !== 1'b0) begin errors++; $display("FAIL wrap_jmp got pc=%h rd=%b exp FF 0", pc, mem_rd); end
        tick(); start = 1'b0;
        checks++; if (mem_addr !== 8'hFF || mem_rd !== 1'b1) begin errors++; $display("FAIL wrap_req got addr=%h rd=%b exp FF 1", mem_addr, mem_rd); end
        tick();
        mem_valid = 1'b1; mem_rdata = 16'h1234; tick(); mem_valid = 1'b0;
        checks++; if (load !== 1'b1 || d !== 16'h1234 || pc !== 8'h00) begin errors++; $display("FAIL wrap_load got load=%b d=%h pc=%h exp 1 1234 00", load, d, pc); end
        checks++; if (mem_addr !== 8'h00 || mem_rd !== 1'b1) begin errors++; $display("FAIL wrap_next got addr=%h rd=%b exp 00 1", mem_addr, mem_rd); end
        halt = 1'b1; tick(); halt = 1'b0;
        mem_valid = 1'b1; mem_rdata = 16'h2222; tick(); mem_valid = 1'b0;
        checks++; if (pc !== 8'h01 || busy !== 1'b0) begin errors++; $display("FAIL wrap_end got pc=%h busy=%b exp 01 0", pc, busy); end
        $display("wrap: d=%h pc=%h", d, pc);
    endtask

    task automatic test_jmp_halt();
        int loads;
        int rds;
        start = 1'b1; tick(); start = 1'b0;
        tick();
        jmp = 1'b1; jmp_addr = 8'h40; halt = 1'b1; tick();
        jmp = 1'b0; halt = 1'b0;
        tick(); tick();
        mem_valid = 1'b1; mem_rdata = 16'h3333; tick(); mem_valid = 1'b0;
        checks++; if (load !== 1'b1 || d !== 16'h3333 || pc !== 8'h40 || busy !== 1'b0) begin errors++; $display("FAIL jmp_halt_load got load=%b d=%h pc=%h busy=%b exp 1 3333 40 0", load, d, pc, busy); end
        loads = 0; rds = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (load === 1'b1) loads++;
            if (mem_rd === 1'b1) rds++;
        end
        checks++; if (loads !== 0 || rds !== 0) begin errors++; $display("FAIL jmp_halt_quiet got loads=%0d rds=%0d exp 0 0", loads, rds); end
        $display("jmp+halt: pc=%h d=%h", pc, d);
    endtask

    task automatic test_timeout();
        int loads;
        start = 1'b1; tick(); start = 1'b0;
        checks++; if (mem_addr !== 8'h40 || mem_rd !== 1'b1) begin errors++; $display("FAIL to_req got addr=%h rd=%b exp 40 1", mem_addr, mem_rd); end
        loads = 0;
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (load === 1'b1) loads++;
            checks++; if (err !== (i == 16)) begin errors++; $display("FAIL to_err_cycle%0d got=%b exp=%b", i, err, (i == 16)); end
        end
        checks++; if (loads !== 0 || pc !== 8'h40 || busy !== 1'b0) begin errors++; $display("FAIL to_state got loads=%0d pc=%h busy=%b exp 0 40 0", loads, pc, busy); end
        start = 1'b1; tick(); start = 1'b0;
        checks++; if (mem_rd !== 1'b0 || err !== 1'b1) begin errors++; $display("FAIL to_start_ignored got rd=%b err=%b exp 0 1", mem_rd, err); end
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        checks++; if (err !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL to_clr got err=%b busy=%b exp 0 0", err, busy); end
        start = 1'b1; tick(); start = 1'b0;
        checks++; if (mem_rd !== 1'b1 || mem_addr !== 8'h40) begin errors++; $display("FAIL to_retry got rd=%b addr=%h exp 1 40", mem_rd, mem_addr); end
        halt = 1'b1; tick(); halt = 1'b0;
        mem_valid = 1'b1; mem_rdata = 16'h5555; tick(); mem_valid = 1'b0;
        checks++; if (load !== 1'b1 || d !== 16'h5555 || pc !== 8'h41) begin errors++; $display("FAIL to_retry_load got load=%b d=%h pc=%h exp 1 5555 41", load, d, pc); end
        $display("timeout: err cleared, retry pc=%h d=%h", pc, d);
    endtask

    task automatic test_en_stall();
        int loads;
        start = 1'b1; tick(); start = 1'b0;
        halt = 1'b1; tick(); halt = 1'b0;
        mem_valid = 1'b1; mem_rdata = 16'hBEEF; en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (load !== 1'b0 || d !== 16'h5555 || pc !== 8'h41 || busy !== 1'b1) begin errors++; $display("FAIL stall_%0d got load=%b d=%h pc=%h busy=%b exp 0 5555 41 1", i, load, d, pc, busy); end
        end
        en = 1'b1; tick(); mem_valid = 1'b0;
        checks++; if (load !== 1'b1 || d !== 16'hBEEF || pc !== 8'h42 || busy !== 1'b0) begin errors++; $display("FAIL stall_release got load=%b d=%h pc=%h busy=%b exp 1 BEEF 42 0", load, d, pc, busy); end
        loads = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (load === 1'b1) loads++;
        end
        checks++; if (loads !== 0) begin errors++; $display("FAIL stall_single_load got extra=%0d exp 0", loads); end
        $display("en stall: d=%h pc=%h", d, pc);
    endtask

    task automatic test_reset_mid();
        start = 1'b1; tick(); start = 1'b0;
        tick();
        rst = 1'b1; tick(); rst = 1'b0;
        mem_valid = 1'b1; mem_rdata = 16'hDEAD; tick(); mem_valid = 1'b0;
        checks++; if (load !== 1'b0 || busy !== 1'b0 || pc !== 8'h00 || d !== 16'h0000) begin errors++; $display("FAIL rst_mid got load=%b busy=%b pc=%h d=%h exp 0 0 00 0000", load, busy, pc, d); end
        tick();
        checks++; if (load !== 1'b0 || mem_rd !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL rst_mid_idle got load=%b rd=%b err=%b exp 0 0 0", load, mem_rd, err); end
        $display("reset mid-transaction: pc=%h busy=%b", pc, busy);
    endtask

    initial begin
        test_reset();
        test_basic_fetch();
        test_wrap();
        test_jmp_halt();
        test_timeout();
        test_en_stall();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
